// File: rtl/mult_div_unit.sv
// Purpose : execute-stage multiply/divide unit with architectural HI/LO registers and mthi/mtlo writes.
// Latency : Busy high for exactly MULT_CYCLES (mul/madd/msub) or DIV_CYCLES (div/divu) cycles after Start; HI/LO update on the edge Busy falls.
// Backpress: none internally; Start and HLRegWrite are ignored while Busy=1 (the hazard unit stalls dependents on Busy).
//
// Ports:
//   clk, reset        - clock and synchronous active-high reset
//   Start, MDOperator - launch an operation (0 multu,1 mult,2 divu,3 div,4 madd,5 maddu,6 msub,7 msubu)
//   HLRegWrite, HLSelect - mthi (HLSelect=1) / mtlo (HLSelect=0) write of A
//   A, B              - rs / rt operands, latched on Start
//   Busy              - operation in flight
//   HI, LO            - architectural HI/LO registers, driven straight from the flops
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDOperator,
    input  logic        HLRegWrite,
    input  logic        HLSelect,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    localparam logic [2:0] OP_MULTU = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_DIVU  = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_MADD  = 3'd4;
    localparam logic [2:0] OP_MADDU = 3'd5;
    localparam logic [2:0] OP_MSUB  = 3'd6;
    localparam logic [2:0] OP_MSUBU = 3'd7;

    logic [3:0]  cnt;
    logic [2:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;

    logic        is_signed_mul;
    logic [63:0] mcand;
    logic [63:0] mplier;
    logic [63:0] prod;
    logic [63:0] hilo;

    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [31:0] dvs_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quo;
    logic [31:0] rem;

    logic [63:0] result;
    logic        result_wr;

    assign Busy = (cnt != 4'd0);
    assign hilo = {HI, LO};

    // Datapath: a single shared multiplier and a single shared divider,
    // both fed from the latched operands so A/B may change mid-operation.
    always_comb begin
        is_signed_mul = (op_q == OP_MULT) || (op_q == OP_MADD) || (op_q == OP_MSUB);
        mcand  = is_signed_mul ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
        mplier = is_signed_mul ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
        // Truncated 64x64 product equals the exact 32x32 product modulo 2^64.
        prod   = mcand * mplier;

        // Signed divide is done on magnitudes, then signs are restored:
        // quotient truncates toward zero, remainder follows the dividend.
        // 0x80000000 / -1 falls out naturally: |a|=0x80000000, |b|=1, signs equal.
        a_mag    = a_q[31] ? (32'd0 - a_q) : a_q;
        b_mag    = b_q[31] ? (32'd0 - b_q) : b_q;
        dvd      = (op_q == OP_DIV) ? a_mag : a_q;
        dvs      = (op_q == OP_DIV) ? b_mag : b_q;
        // Divide by zero never commits; a dummy divisor keeps the divider defined.
        dvs_safe = (dvs == 32'd0) ? 32'd1 : dvs;
        q_mag    = dvd / dvs_safe;
        r_mag    = dvd % dvs_safe;

        quo = q_mag;
        rem = r_mag;
        if (op_q == OP_DIV) begin
            quo = (a_q[31] ^ b_q[31]) ? (32'd0 - q_mag) : q_mag;
            rem = a_q[31] ? (32'd0 - r_mag) : r_mag;
        end

        result    = hilo;
        result_wr = 1'b1;
        case (op_q)
            OP_MULTU, OP_MULT: result = prod;
            OP_DIVU, OP_DIV: begin
                result    = {rem, quo};
                result_wr = (b_q != 32'd0);
            end
            OP_MADD, OP_MADDU: result = hilo + prod;
            OP_MSUB, OP_MSUBU: result = hilo - prod;
            default:           result = hilo;
        endcase
    end

    // Control: cnt==0 is idle. Start wins over HLRegWrite in the same idle
    // cycle; both are ignored while cnt!=0, including the final busy cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= 4'd0;
            op_q <= 3'd0;
            a_q  <= 32'd0;
            b_q  <= 32'd0;
            HI   <= 32'd0;
            LO   <= 32'd0;
        end else if (cnt == 4'd0) begin
            if (Start) begin
                op_q <= MDOperator;
                a_q  <= A;
                b_q  <= B;
                cnt  <= (MDOperator[2:1] == 2'b01) ? DIV_LOAD : MULT_LOAD;
            end else if (HLRegWrite) begin
                if (HLSelect) begin
                    HI <= A;
                end else begin
                    LO <= A;
                end
            end
        end else begin
            cnt <= cnt - 4'd1;
            if ((cnt == 4'd1) && result_wr) begin
                HI <= result[63:32];
                LO <= result[31:0];
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        Start;
    logic [2:0]  MDOperator;
    logic        HLRegWrite;
    logic        HLSelect;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int total;
    int bad;
    logic [31:0] hi_m;
    logic [31:0] lo_m;

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .Start      (Start),
        .MDOperator (MDOperator),
        .HLRegWrite (HLRegWrite),
        .HLSelect   (HLSelect),
        .A          (A),
        .B          (B),
        .Busy       (Busy),
        .HI         (HI),
        .LO         (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: {HI,LO} after an operation, straight from the arithmetic rules.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] hl);
        longint          sa, sb, ps;
        longint unsigned ua, ub, pu;
        int              ia, ib, q, r;
        sa = $signed(a);
        sb = $signed(b);
        ps = sa * sb;
        ua = a;
        ub = b;
        pu = ua * ub;
        ia = a;
        ib = b;
        case (op)
            3'd0: return pu;
            3'd1: return ps;
            3'd2: begin
                if (b == 0) return hl;
                return {a % b, a / b};
            end
            3'd3: begin
                if (b == 0) return hl;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = ia / ib;
                r = ia % ib;
                return {r, q};
            end
            3'd4: return hl + ps;
            3'd5: return hl + pu;
            3'd6: return hl - ps;
            default: return hl - pu;
        endcase
    endfunction

    // inj: 0 none, 1 mtlo during busy, 2 Start in last busy cycle, 3 mthi together with Start
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int inj);
        logic [63:0] exp;
        int n;
        exp = model(op, a, b, {hi_m, lo_m});
        n = (op == 3'd2 || op == 3'd3) ? 10 : 5;
        @(negedge clk);
        Start = 1'b1; MDOperator = op; A = a; B = b;
        if (inj == 3) begin HLRegWrite = 1'b1; HLSelect = 1'b1; end
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (i == 1) begin
                Start = 1'b0; HLRegWrite = 1'b0; A = $urandom; B = $urandom;
            end
            chk($sformatf("busy_op%0d_cyc%0d", op, i), {63'd0, Busy}, 64'd1);
            chk($sformatf("hold_op%0d_cyc%0d", op, i), {HI, LO}, {hi_m, lo_m});
            if (inj == 1 && i == 2) begin HLRegWrite = 1'b1; HLSelect = 1'b0; A = $urandom; end
            if (inj == 1 && i == 3) HLRegWrite = 1'b0;
            if (inj == 2 && i == n) begin Start = 1'b1; MDOperator = 3'd1; A = $urandom; B = $urandom; end
        end
        @(negedge clk);
        Start = 1'b0; HLRegWrite = 1'b0;
        chk($sformatf("done_busy_op%0d", op), {63'd0, Busy}, 64'd0);
        chk($sformatf("result_op%0d_a%h_b%h", op, a, b), {HI, LO}, exp);
        {hi_m, lo_m} = exp;
        if (inj == 2) begin
            @(negedge clk);
            chk("no_second_busy", {63'd0, Busy}, 64'd0);
            chk("no_second_result", {HI, LO}, {hi_m, lo_m});
        end
    endtask

    task automatic mt(input logic sel, input logic [31:0] val);
        @(negedge clk);
        HLRegWrite = 1'b1; HLSelect = sel; A = val;
        @(negedge clk);
        HLRegWrite = 1'b0;
        if (sel) hi_m = val; else lo_m = val;
        chk(sel ? "mthi" : "mtlo", {HI, LO}, {hi_m, lo_m});
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        total = 0; bad = 0;
        reset = 1'b1; Start = 1'b0; MDOperator = 3'd0; HLRegWrite = 1'b0; HLSelect = 1'b0;
        A = 32'd0; B = 32'd0;
        hi_m = 32'd0; lo_m = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset_busy", {63'd0, Busy}, 64'd0);
        chk("reset_hilo", {HI, LO}, 64'd0);

        // directed cases
        run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 0);
        chk("mult_const", {HI, LO}, {32'hFFFF_FFFF, 32'hFFFF_FFFA});
        run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        chk("multu_const", {HI, LO}, {32'hFFFF_FFFE, 32'h0000_0001});
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 0);
        chk("div_const", {HI, LO}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_op(3'd2, 32'd7, 32'd0, 0);
        chk("divu_zero_const", {HI, LO}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        chk("div_ovf_const", {HI, LO}, {32'h0, 32'h8000_0000});
        mt(1'b1, 32'd0);
        mt(1'b0, 32'hFFFF_FFFF);
        run_op(3'd5, 32'd1, 32'd1, 0);
        chk("maddu_const", {HI, LO}, {32'd1, 32'd0});
        run_op(3'd6, 32'd1, 32'd1, 0);
        chk("msub_const", {HI, LO}, {32'd0, 32'hFFFF_FFFF});

        // reset during the third busy cycle aborts the operation
        @(negedge clk);
        Start = 1'b1; MDOperator = 3'd1; A = 32'd2; B = 32'd3;
        @(negedge clk);
        Start = 1'b0;
        chk("abort_busy1", {63'd0, Busy}, 64'd1);
        @(negedge clk);
        chk("abort_busy2", {63'd0, Busy}, 64'd1);
        @(negedge clk);
        chk("abort_busy3", {63'd0, Busy}, 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        hi_m = 32'd0; lo_m = 32'd0;
        chk("abort_busy", {63'd0, Busy}, 64'd0);
        chk("abort_hilo", {HI, LO}, 64'd0);
        repeat (6) @(negedge clk);
        chk("abort_no_commit", {HI, LO}, 64'd0);

        // mtlo while busy is dropped
        run_op(3'd1, 32'd7, 32'd6, 1);
        chk("mtlo_busy_dropped", {HI, LO}, {32'd0, 32'd42});
        // Start beats a same-cycle mthi
        mt(1'b1, 32'd9);
        run_op(3'd0, 32'd4, 32'd5, 3);
        chk("start_beats_mthi", {HI, LO}, {32'd0, 32'd20});
        // Start during the final busy cycle is ignored
        run_op(3'd1, $urandom, $urandom, 2);

        // randomized mix
        for (int k = 0; k < 40; k++) begin
            rop = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) rb = 32'd0;
            if ($urandom_range(0, 15) == 0) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            if ($urandom_range(0, 4) == 0) mt(1'($urandom_range(0, 1)), $urandom);
            run_op(rop, ra, rb, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
